// File: rtl/char_reg.sv
// char_reg: two-class binary character recogniser for one 8x8 image.
//
// The image and both class templates are parameters. After reset is released
// the block walks the 64 pixels, one per clock. For each class it counts the
// pixels where the image agrees with that class's template. One compare cycle
// follows, and then the decision is held until the next reset.
//
// Pixel i is bit i of each 64-bit parameter; row r is bits [8r+7:8r].
//
// Ports:
//   clk  - system clock, rising-edge active
//   rst  - asynchronous reset, active low (rst=0 clears all state)
//   ans  - registered decision: 1 = class 1, 0 = class 0 / tie / not decided
//
// All architectural state lives in the packed struct `r` (state, idx, score0,
// score1, ans), so a checker can bind to a single signal.
module char_reg #(
  parameter logic [63:0] IMAGE = 64'h1818_1838_1818_1818,
  parameter logic [63:0] TMPL0 = 64'h3C66_6666_6666_663C,
  parameter logic [63:0] TMPL1 = 64'h1818_1818_1818_1818,
  parameter int          NPIX  = 64
) (
  input  logic clk,
  input  logic rst,
  output logic ans
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [5:0]  idx;
    logic [6:0]  score0;
    logic [6:0]  score1;
    logic        ans;
  } regs_t;

  regs_t r;
  regs_t r_nxt;

  logic match0;
  logic match1;

  // A pixel matches a template when both bits agree (XNOR).
  assign match0 = ~(IMAGE[r.idx] ^ TMPL0[r.idx]);
  assign match1 = ~(IMAGE[r.idx] ^ TMPL1[r.idx]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r.state  <= RUN;
      r.idx    <= 6'd0;
      r.score0 <= 7'd0;
      r.score1 <= 7'd0;
      r.ans    <= 1'b0;
    end else begin
      r <= r_nxt;
    end
  end

  always_comb begin
    r_nxt = r;
    case (r.state)
      RUN: begin
        r_nxt.score0 = r.score0 + {6'd0, match0};
        r_nxt.score1 = r.score1 + {6'd0, match1};
        // idx wraps to 0 after pixel 63; it is not used again until reset.
        r_nxt.idx    = r.idx + 6'd1;
        if (r.idx == 6'd63) begin
          r_nxt.state = CMP;
        end
      end
      CMP: begin
        // Strictly greater: a tie resolves to class 0.
        r_nxt.ans   = (r.score1 > r.score0);
        r_nxt.state = DONE;
      end
      DONE: begin
        r_nxt = r;
      end
      default: begin
        r_nxt.state = DONE;
      end
    endcase
  end

  assign ans = r.ans;

endmodule

// File: tb/tb_char_reg.sv
// Bench for char_reg: four instances with different image/template sets share
// one clock and one reset. A vector table lists edge counts after reset release
// together with the expected ans of every instance. Hand-written sequences then
// cover the long hold, a reset in the middle of a scan, and a short reset pulse
// while the block is in DONE.
module tb_char_reg;

  logic clk;
  logic rst;
  logic ans0, ans1, ans2, ans3;
  logic [3:0] ans_v;

  int total = 0;
  int bad = 0;
  int n = 0;  // rising edges seen since the last reset release

  // u0: default parameters            -> score0=25, score1=63, ans=1
  // u1: IMAGE = TMPL0                 -> score0=64, score1=24, ans=0
  // u2: tie, IMAGE=0, equal templates -> score0=score1=32,     ans=0
  // u3: IMAGE = TMPL1                 -> score0=24, score1=64, ans=1
  char_reg u0 (.clk(clk), .rst(rst), .ans(ans0));

  char_reg #(
    .IMAGE(64'h3C66_6666_6666_663C)
  ) u1 (.clk(clk), .rst(rst), .ans(ans1));

  char_reg #(
    .IMAGE(64'h0),
    .TMPL0(64'hFFFF_0000_FFFF_0000),
    .TMPL1(64'hFFFF_0000_FFFF_0000)
  ) u2 (.clk(clk), .rst(rst), .ans(ans2));

  char_reg #(
    .IMAGE(64'h1818_1818_1818_1818)
  ) u3 (.clk(clk), .rst(rst), .ans(ans3));

  assign ans_v = {ans3, ans2, ans1, ans0};

  // Clock: period 10 ns, falling edges at 5, 15, ...; rising edges at 10, 20, ...
  initial begin
    clk = 1'b1;
    forever begin
      #5;
      clk = ~clk;
    end
  end

  typedef struct {
    int         edge_no;
    logic [3:0] exp_ans;  // bit k is the expected ans of instance uk
  } vec_t;

  vec_t vecs[9];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] exp);
    chk1({name, "/u0"}, ans_v[0], exp[0]);
    chk1({name, "/u1"}, ans_v[1], exp[1]);
    chk1({name, "/u2"}, ans_v[2], exp[2]);
    chk1({name, "/u3"}, ans_v[3], exp[3]);
  endtask

  // Advance to the given edge count, then sample 2 ns after that edge.
  task automatic advance(input int target);
    while (n < target) begin
      @(posedge clk);
      n++;
    end
    #2;
  endtask

  // Called 2 ns after a rising edge: drop rst for 3 ns and release it on the
  // following falling edge, restarting the edge count.
  task automatic pulse_reset(input string name);
    rst = 1'b0;
    #1;
    chk_all({name, "_async"}, 4'b0000);
    chk7({name, "_idx"}, {1'b0, u0.r.idx}, 7'd0);
    chk7({name, "_score0"}, u0.r.score0, 7'd0);
    chk7({name, "_score1"}, u0.r.score1, 7'd0);
    #2;
    rst = 1'b1;
    n = 0;
  endtask

  initial begin
    vecs[0] = '{0,   4'b0000};
    vecs[1] = '{1,   4'b0000};
    vecs[2] = '{30,  4'b0000};
    vecs[3] = '{63,  4'b0000};
    vecs[4] = '{64,  4'b0000};
    vecs[5] = '{65,  4'b1001};
    vecs[6] = '{66,  4'b1001};
    vecs[7] = '{70,  4'b1001};
    vecs[8] = '{200, 4'b1001};

    // Hold reset low from t=0 and release at 5 ns (a falling edge).
    rst = 1'b0;
    #1;
    chk_all("reset_hold", 4'b0000);
    #4;
    rst = 1'b1;
    n = 0;

    for (int i = 0; i < 9; i++) begin
      advance(vecs[i].edge_no);
      chk_all($sformatf("vec_edge%0d", vecs[i].edge_no), vecs[i].exp_ans);
      if (n < vecs[i].edge_no) n = vecs[i].edge_no;
    end

    // Final match counts of every instance.
    chk7("u0_score0", u0.r.score0, 7'd25);
    chk7("u0_score1", u0.r.score1, 7'd63);
    chk7("u1_score0", u1.r.score0, 7'd64);
    chk7("u1_score1", u1.r.score1, 7'd24);
    chk7("u2_score0", u2.r.score0, 7'd32);
    chk7("u2_score1", u2.r.score1, 7'd32);
    chk7("u3_score0", u3.r.score0, 7'd24);
    chk7("u3_score1", u3.r.score1, 7'd64);

    // The decision holds for a long time with no rescan (past 100 us).
    advance(10000);
    chk_all("hold_100us", 4'b1001);
    chk7("hold_u0_score0", u0.r.score0, 7'd25);

    // Reset asserted in the middle of a scan, at edge 30.
    pulse_reset("pre_mid");
    advance(30);
    chk_all("mid_before", 4'b0000);
    pulse_reset("mid");
    advance(64);
    chk_all("mid_edge64", 4'b0000);
    advance(65);
    chk_all("mid_edge65", 4'b1001);

    // Short reset pulse while in DONE.
    advance(80);
    chk_all("done_before", 4'b1001);
    pulse_reset("done");
    advance(1);
    chk_all("done_edge1", 4'b0000);
    advance(64);
    chk_all("done_edge64", 4'b0000);
    advance(65);
    chk_all("done_edge65", 4'b1001);
    advance(100);
    chk_all("done_edge100", 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_reg.md
Name: char_reg

Overview:
- Self-contained two-class binary character recogniser for an 8x8 monochrome image.
- The image and both class templates are compile-time parameters held on chip.
- After reset release it scans the image one pixel per clock. For each class it counts the pixels that match that class's template.
- It then outputs a single decision bit on ans and holds it until the next reset.
- Top-level leaf block; the board or bench supplies only clock and reset.

Parameters:
- IMAGE, 64'h1818_1838_1818_1818, input image. Pixel i is IMAGE[i]; row r is bits [8r+7:8r]; column c is bit 8r+c.
- TMPL0, 64'h3C66_6666_6666_663C, class-0 template ("0" glyph), same bit layout.
- TMPL1, 64'h1818_1818_1818_1818, class-1 template ("1" glyph), same bit layout.
- NPIX, 64, pixel count. Fixed at 64; other values are not supported.

Ports:
- clk, input, 1, system clock. Rising-edge active.
- rst, input, 1, asynchronous active-low reset (rst=0 resets).
- ans, output, 1, registered classification result. 1 = class 1, 0 = class 0 or not yet decided.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state is updated on the rising edge of clk.
  - rst low asynchronously forces: state=RUN, idx=0, score0=0, score1=0, ans=0.
  - Reset asserted mid-scan or in DONE clears everything. The scan restarts from pixel 0 after release.
- Internal state:
  - idx: 6-bit pixel index.
  - score0, score1: 7-bit unsigned match counters, range 0..64.
  - FSM states RUN, CMP, DONE.
- RUN, per rising edge:
  - score0 += (IMAGE[idx] XNOR TMPL0[idx]).
  - score1 += (IMAGE[idx] XNOR TMPL1[idx]).
  - If idx==63, go to CMP (idx may wrap to 0). Otherwise idx += 1.
  - Exactly 64 pixels are accumulated, each once. Counters cannot overflow (max 64 fits in 7 bits).
- CMP, one edge:
  - ans <= (score1 > score0), unsigned compare.
  - A tie gives ans=0.
  - Next state is DONE.
- DONE:
  - All registers hold; ans is stable indefinitely. There is no automatic rescan.
- Latency:
  - ans updates on the 65th rising edge after rst deasserts: 64 RUN edges plus 1 CMP edge.
  - Before that edge ans reads 0.
- ans is driven directly from a flop; there is no combinational path from rst release.
- Default-parameter result: score0=25, score1=63, so ans=1.

Test Plan:
1. Default parameters; hold rst=0 for 5 ns, then release; free-running clock -> ans=0 through edge 64 after release; ans=1 from edge 65; still 1 at 100 us.
2. IMAGE=TMPL0 (64'h3C66_6666_6666_663C), default templates -> score0=64, score1=24, so ans=0. Check ans remains 0 after edge 65.
3. Tie: IMAGE=64'h0, TMPL0=TMPL1=64'hFFFF_0000_FFFF_0000 -> score0=score1=32, so ans=0.
4. IMAGE=TMPL1 exactly -> score1=64, score0=24, so ans=1 at edge 65.
5. Reset mid-run (default parameters):
   - Assert rst low at edge 30 -> ans=0 immediately.
   - Release -> ans=1 exactly 65 edges after the second release, not earlier.
6. Reset in DONE (default parameters): ans=1; pulse rst low for 3 ns between edges -> ans drops to 0 asynchronously, then returns to 1 on the 65th edge after release.
